img2col_window_feeder: RTL and testbench
========================================

Name: img2col_window_feeder

Overview:
- Upstream stage of the img2col register file.
- Walks a row-major feature map in on-chip SRAM and emits every K x K sliding window as an ordered pixel stream.
- Each stream element carries valid/ready and a last-of-window flag, and feeds the register file's shift-in data/act inputs.
- Handles the SRAM's 1-cycle read latency and downstream backpressure with a 2-entry output FIFO.

Parameters:
DATA_WIDTH, 16, pixel width
ADDR_WIDTH, 12, SRAM address width
DIM_WIDTH, 6, width of image dimension and window coordinate fields
K_MAX, 5, largest supported kernel size

Ports:
clk  in  1  clock, rising edge
nrst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; latches config and starts a job when idle
img_w  in  DIM_WIDTH  image width W
img_h  in  DIM_WIDTH  image height H
k_size  in  3  kernel size K
stride  in  2  stride S
base_addr  in  ADDR_WIDTH  SRAM address of pixel (0,0)
mem_rd_en  out  1  SRAM read strobe
mem_addr  out  ADDR_WIDTH  SRAM read address
mem_rdata  in  DATA_WIDTH  SRAM data, valid 1 cycle after mem_rd_en
out_data  out  DATA_WIDTH  pixel to register file
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid and out_ready are both high
out_last  out  1  element is the last (K*K-th) of its window
win_row  out  DIM_WIDTH  output-window row of current element
win_col  out  DIM_WIDTH  output-window column of current element
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
cfg_err  out  1  latched config error

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO emptied, in-flight read discarded. Applies at any time, including mid-job.
- Config is latched on start in IDLE; start is ignored while busy.
- Derived sizes: OH = (H-K)/S + 1 and OW = (W-K)/S + 1, integer division.
- Config error when K=0, K>K_MAX, S=0, K>W or K>H.
  - On error: no reads issued, FSM goes to DONE, done pulses the next cycle.
  - cfg_err stays 1 until the next accepted start.
- Element order: window raster order (r = 0..OH-1 outer, c = 0..OW-1), then kernel row i, then kernel column j.
  - Address = base_addr + (r*S + i)*W + (c*S + j), computed modulo 2^ADDR_WIDTH.
  - Use incremental row-base/column counters, not multipliers.
- FSM:
  - IDLE -> RUN on start with valid config. busy=1 from the cycle after start.
  - RUN: a read is issued (mem_rd_en=1) in any cycle where FIFO occupancy + in-flight reads < 2.
  - RUN -> DRAIN in the cycle after the last address is issued.
  - DRAIN -> DONE when the FIFO is empty and no read is in flight.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Read data is written to the FIFO in the cycle after issue.
  - Each FIFO entry holds data, last, win_row and win_col; the tags are captured at issue time and travel with the read.
- Output:
  - out_valid = FIFO not empty; outputs come from the FIFO head.
  - The head pops on the out_valid and out_ready handshake.
  - When the FIFO is empty, out_data and tags hold their last values.
- Throughput: with out_ready held high, 1 element per cycle. First out_valid comes 2 cycles after start.
- Backpressure: at most 2 elements are outstanding (FIFO + in-flight). No loss, duplication or reordering.
- A push and a pop in the same cycle keep the occupancy unchanged.
- Job totals: OH*OW*K*K reads and handshakes; out_last asserted exactly OH*OW times.

Test Plan:
- SRAM[a]=a, base 0, W=H=4, K=3, S=1, out_ready=1 -> 36 elements. Window (0,0) = 0,1,2,4,5,6,8,9,10 with out_last on 10. Window (1,1) starts at 5. Done pulses once, busy low afterwards.
- W=H=5, K=3, S=2, base 100 -> 4 windows. Window (0,1) = 102,103,104,107,108,109,112,113,114.
- Same as case 1 with out_ready low for 5 cycles mid-window -> mem_rd_en low while 2 are outstanding. Stream identical to case 1, gap-free after out_ready returns high.
- K=5, W=4 -> cfg_err=1, done one cycle after start, mem_rd_en never asserted. Next valid start clears cfg_err.
- nrst low mid-RUN, then a new start -> outputs 0 during reset, no stale element emitted, second job stream correct from element 0.
- Second start pulse while busy -> ignored; output count and done timing unchanged. Base 4090 with a wrapping address -> mem_addr wraps mod 4096.

Source files
------------

// File: rtl/img2col_window_feeder.sv
// Streams every K x K sliding window of a row-major feature map held in SRAM.
// A 2-entry output FIFO absorbs the 1-cycle read latency and downstream backpressure.
module img2col_window_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int DIM_WIDTH  = 6,
    parameter int K_MAX      = 5
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  img_w,
    input  logic [DIM_WIDTH-1:0]  img_h,
    input  logic [2:0]            k_size,
    input  logic [1:0]            stride,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [DIM_WIDTH-1:0]  win_row,
    output logic [DIM_WIDTH-1:0]  win_col,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);
    localparam int PW = DIM_WIDTH + 2;
    localparam logic [2:0] KMAX3 = 3'(K_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, next_state;

    logic [DIM_WIDTH-1:0]  w_q, h_q, r_q, c_q;
    logic [2:0]            k_q, i_q, j_q, k_last;
    logic [1:0]            s_q;
    logic [PW-1:0]         rs_q, cs_q;
    logic [ADDR_WIDTH-1:0] row_start_q, win_base_q, row_base_q;
    logic [ADDR_WIDTH-1:0] w_a, s_a, sw;

    logic                  vld_p0, last_p0;
    logic [DIM_WIDTH-1:0]  row_p0, col_p0;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  fifo_last [2];
    logic [DIM_WIDTH-1:0]  fifo_row  [2];
    logic [DIM_WIDTH-1:0]  fifo_col  [2];
    logic [1:0]            cnt;
    logic                  wr_ptr, rd_ptr, head;
    logic                  push, pop;
    logic [2:0]            occ, limit;

    logic accept, cfg_bad, j_end, i_end, col_more, row_more, last_elem;

    assign accept  = (state == IDLE) && start;
    assign cfg_bad = (k_size == 3'd0) || (k_size > KMAX3) || (stride == 2'd0) ||
                     (DIM_WIDTH'(k_size) > img_w) || (DIM_WIDTH'(k_size) > img_h);

    assign k_last    = k_q - 3'd1;
    assign j_end     = (j_q == k_last);
    assign i_end     = (i_q == k_last);
    // Another window fits if its right/bottom edge stays inside the image; avoids a divider.
    assign col_more  = (cs_q + PW'(s_q) + PW'(k_q)) <= PW'(w_q);
    assign row_more  = (rs_q + PW'(s_q) + PW'(k_q)) <= PW'(h_q);
    assign last_elem = j_end && i_end && !col_more && !row_more;

    assign w_a = ADDR_WIDTH'(w_q);
    assign s_a = ADDR_WIDTH'(s_q);
    always_comb begin
        sw = w_a;
        case (s_q)
            2'd2:    sw = w_a << 1;
            2'd3:    sw = w_a + (w_a << 1);
            default: sw = w_a;
        endcase
    end

    assign mem_addr = row_base_q + ADDR_WIDTH'(j_q);

    // Read credit counts a pop in the same cycle so a full-rate stream never stalls.
    assign push  = vld_p0;
    assign pop   = out_valid && out_ready;
    assign occ   = {1'b0, cnt} + {2'b00, vld_p0};
    assign limit = 3'd2 + {2'b00, pop};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = cfg_bad ? DONE : RUN;
            RUN:     if (mem_rd_en && last_elem) next_state = DRAIN;
            DRAIN:   if (cnt == 2'd0 && !vld_p0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN) || (state == DRAIN);
        done      = (state == DONE);
        mem_rd_en = (state == RUN) && (occ < limit);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            w_q <= '0; h_q <= '0; k_q <= '0; s_q <= '0; cfg_err <= 1'b0;
            i_q <= '0; j_q <= '0; r_q <= '0; c_q <= '0; rs_q <= '0; cs_q <= '0;
            row_start_q <= '0; win_base_q <= '0; row_base_q <= '0;
        end else if (accept) begin
            w_q <= img_w; h_q <= img_h; k_q <= k_size; s_q <= stride; cfg_err <= cfg_bad;
            i_q <= '0; j_q <= '0; r_q <= '0; c_q <= '0; rs_q <= '0; cs_q <= '0;
            row_start_q <= base_addr; win_base_q <= base_addr; row_base_q <= base_addr;
        end else if (mem_rd_en) begin
            if (!j_end) begin
                j_q <= j_q + 3'd1;
            end else begin
                j_q <= '0;
                if (!i_end) begin
                    i_q        <= i_q + 3'd1;
                    row_base_q <= row_base_q + w_a;
                end else begin
                    i_q <= '0;
                    if (col_more) begin
                        c_q        <= c_q + DIM_WIDTH'(1);
                        cs_q       <= cs_q + PW'(s_q);
                        win_base_q <= win_base_q + s_a;
                        row_base_q <= win_base_q + s_a;
                    end else begin
                        c_q  <= '0;
                        cs_q <= '0;
                        if (row_more) begin
                            r_q         <= r_q + DIM_WIDTH'(1);
                            rs_q        <= rs_q + PW'(s_q);
                            row_start_q <= row_start_q + sw;
                            win_base_q  <= row_start_q + sw;
                            row_base_q  <= row_start_q + sw;
                        end
                    end
                end
            end
        end
    end

    // Stage p0: tags of the read in flight, aligned with mem_rdata
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_p0 <= 1'b0; last_p0 <= 1'b0; row_p0 <= '0; col_p0 <= '0;
        end else begin
            vld_p0 <= mem_rd_en;
            if (mem_rd_en) begin
                last_p0 <= j_end && i_end;
                row_p0  <= r_q;
                col_p0  <= c_q;
            end
        end
    end

    // Stage p1: output FIFO
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int n = 0; n < 2; n++) begin
                fifo_data[n] <= '0; fifo_last[n] <= 1'b0; fifo_row[n] <= '0; fifo_col[n] <= '0;
            end
            wr_ptr <= 1'b0; rd_ptr <= 1'b0; cnt <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_rdata;
                fifo_last[wr_ptr] <= last_p0;
                fifo_row[wr_ptr]  <= row_p0;
                fifo_col[wr_ptr]  <= col_p0;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

    // When empty, the slot behind the read pointer still holds the last popped element.
    assign head      = (cnt != 2'd0) ? rd_ptr : ~rd_ptr;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = fifo_data[head];
    assign out_last  = fifo_last[head];
    assign win_row   = fifo_row[head];
    assign win_col   = fifo_col[head];
endmodule

// File: tb/tb_img2col_window_feeder.sv
// Directed bench for img2col_window_feeder: identity SRAM (mem[a] = a), stream
// captured on handshakes and compared against a nested-loop window model.
module tb_img2col_window_feeder;
    logic        clk = 1'b0, nrst = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic [5:0]  img_w = '0, img_h = '0;
    logic [2:0]  k_size = '0;
    logic [1:0]  stride = '0;
    logic [11:0] base_addr = '0;
    logic        mem_rd_en, out_valid, out_last, busy, done, cfg_err;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata = '0, out_data;
    logic [5:0]  win_row, win_col;

    img2col_window_feeder dut (
        .clk(clk), .nrst(nrst), .start(start), .img_w(img_w), .img_h(img_h),
        .k_size(k_size), .stride(stride), .base_addr(base_addr),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .win_row(win_row), .win_col(win_col),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    typedef struct packed {
        logic        last;
        logic [5:0]  row;
        logic [5:0]  col;
        logic [15:0] data;
    } elem_t;

    logic [15:0] mem [0:4095];
    elem_t got_q[$], exp_q[$];
    int pop_cyc_q[$];
    int cyc = 0, checks = 0, passes = 0;
    int rd_cnt = 0, done_cnt = 0, first_valid_cyc = -1, done_cyc = -1, start_cyc = 0;
    bit over_flag = 1'b0, timed_out = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    always @(negedge clk) begin
        if (nrst) begin
            if (mem_rd_en) rd_cnt++;
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, win_row, win_col, out_data});
                pop_cyc_q.push_back(cyc);
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (rd_cnt - got_q.size() > 2) over_flag = 1'b1;
        end
    end

    task automatic clear_mon();
        got_q.delete(); pop_cyc_q.delete();
        rd_cnt = 0; done_cnt = 0; first_valid_cyc = -1; done_cyc = -1;
        over_flag = 1'b0; timed_out = 1'b0;
    endtask

    task automatic build_exp(input int w, input int h, input int k, input int s, input int base);
        int oh, ow, a;
        elem_t e;
        exp_q.delete();
        oh = (h - k) / s + 1;
        ow = (w - k) / s + 1;
        for (int r = 0; r < oh; r++)
            for (int c = 0; c < ow; c++)
                for (int i = 0; i < k; i++)
                    for (int j = 0; j < k; j++) begin
                        a = (base + (r * s + i) * w + c * s + j) % 4096;
                        e.last = (i == k - 1) && (j == k - 1);
                        e.row  = 6'(r);
                        e.col  = 6'(c);
                        e.data = mem[a];
                        exp_q.push_back(e);
                    end
    endtask

    task automatic start_job(input int w, input int h, input int k, input int s, input int base);
        img_w = 6'(w); img_h = 6'(h); k_size = 3'(k); stride = 2'(s); base_addr = 12'(base);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 500 && done_cnt == 0; n++) begin
            @(posedge clk); #1;
        end
        timed_out = (done_cnt == 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if ({out_valid, busy, done, cfg_err, mem_rd_en} !== 5'b0) $display("FAIL rst_ctrl got %b exp 00000", {out_valid, busy, done, cfg_err, mem_rd_en}); else passes++;
        checks++; if (out_data !== 16'h0) $display("FAIL rst_data got %h exp 0000", out_data); else passes++;
        checks++; if ({out_last, win_row, win_col} !== 13'h0) $display("FAIL rst_tags got %h exp 0", {out_last, win_row, win_col}); else passes++;
        checks++; if (mem_addr !== 12'h0) $display("FAIL rst_addr got %h exp 000", mem_addr); else passes++;
        nrst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if ({busy, out_valid, mem_rd_en} !== 3'b0) $display("FAIL rst_idle got %b exp 000", {busy, out_valid, mem_rd_en}); else passes++;
    endtask

    task automatic test_basic();
        int lasts = 0;
        clear_mon(); build_exp(4, 4, 3, 1, 0);
        start_job(4, 4, 3, 1, 0);
        wait_done();
        checks++; if (timed_out) $display("FAIL basic_timeout got no done exp done"); else passes++;
        checks++; if (first_valid_cyc - start_cyc != 2) $display("FAIL basic_first_valid got %0d exp 2", first_valid_cyc - start_cyc); else passes++;
        checks++; if (got_q.size() != 36) $display("FAIL basic_count got %0d exp 36", got_q.size()); else passes++;
        for (int n = 0; n < exp_q.size(); n++) begin
            checks++;
            if (n >= got_q.size()) $display("FAIL basic_elem[%0d] got none exp %h", n, exp_q[n]);
            else if (got_q[n] !== exp_q[n]) $display("FAIL basic_elem[%0d] got %h exp %h", n, got_q[n], exp_q[n]);
            else passes++;
        end
        foreach (got_q[n]) if (got_q[n].last) lasts++;
        checks++; if (lasts != 4) $display("FAIL basic_lasts got %0d exp 4", lasts); else passes++;
        checks++; if (got_q.size() > 8 && (got_q[8].data !== 16'd10 || got_q[8].last !== 1'b1)) $display("FAIL basic_w00_end got %h exp data 10 last 1", got_q[8]); else passes++;
        checks++; if (got_q.size() > 27 && (got_q[27].data !== 16'd5 || got_q[27].row !== 6'd1 || got_q[27].col !== 6'd1)) $display("FAIL basic_w11_start got %h exp data 5 row 1 col 1", got_q[27]); else passes++;
        checks++; if (rd_cnt != 36) $display("FAIL basic_reads got %0d exp 36", rd_cnt); else passes++;
        checks++; if (done_cnt != 1) $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); else passes++;
        checks++; if (done_cyc - start_cyc != 39) $display("FAIL basic_done_time got %0d exp 39", done_cyc - start_cyc); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after got %b exp 0", busy); else passes++;
        checks++; if (pop_cyc_q.size() != 36 || pop_cyc_q[35] - pop_cyc_q[0] != 35) $display("FAIL basic_gapfree got %0d pops exp 36 in 36 cycles", pop_cyc_q.size()); else passes++;
    endtask

    task automatic test_stride2();
        clear_mon(); build_exp(5, 5, 3, 2, 100);
        start_job(5, 5, 3, 2, 100);
        wait_done();
        checks++; if (timed_out) $display("FAIL s2_timeout got no done exp done"); else passes++;
        checks++; if (got_q.size() != 36) $display("FAIL s2_count got %0d exp 36", got_q.size()); else passes++;
        for (int n = 0; n < exp_q.size(); n++) begin
            checks++;
            if (n >= got_q.size()) $display("FAIL s2_elem[%0d] got none exp %h", n, exp_q[n]);
            else if (got_q[n] !== exp_q[n]) $display("FAIL s2_elem[%0d] got %h exp %h", n, got_q[n], exp_q[n]);
            else passes++;
        end
        checks++; if (got_q.size() > 9 && (got_q[9].data !== 16'd102 || got_q[9].row !== 6'd0 || got_q[9].col !== 6'd1)) $display("FAIL s2_w01_start got %h exp data 102 row 0 col 1", got_q[9]); else passes++;
        checks++; if (got_q.size() > 17 && (got_q[17].data !== 16'd114 || got_q[17].last !== 1'b1)) $display("FAIL s2_w01_end got %h exp data 114 last 1", got_q[17]); else passes++;
        checks++; if (done_cnt != 1) $display("FAIL s2_done_cnt got %0d exp 1", done_cnt); else passes++;
    endtask

    task automatic test_backpressure();
        int gaps = 0, gap_len = 0;
        clear_mon(); build_exp(4, 4, 3, 1, 0);
        start_job(4, 4, 3, 1, 0);
        for (int n = 0; n < 50 && got_q.size() < 4; n++) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        checks++; if ({mem_rd_en, out_valid} !== 2'b01) $display("FAIL bp_stalled got rd_en,valid=%b exp 01", {mem_rd_en, out_valid}); else passes++;
        out_ready = 1'b1;
        wait_done();
        checks++; if (timed_out) $display("FAIL bp_timeout got no done exp done"); else passes++;
        checks++; if (over_flag) $display("FAIL bp_outstanding got >2 exp <=2"); else passes++;
        checks++; if (got_q.size() != 36) $display("FAIL bp_count got %0d exp 36", got_q.size()); else passes++;
        for (int n = 0; n < exp_q.size(); n++) begin
            checks++;
            if (n >= got_q.size()) $display("FAIL bp_elem[%0d] got none exp %h", n, exp_q[n]);
            else if (got_q[n] !== exp_q[n]) $display("FAIL bp_elem[%0d] got %h exp %h", n, got_q[n], exp_q[n]);
            else passes++;
        end
        for (int n = 1; n < pop_cyc_q.size(); n++)
            if (pop_cyc_q[n] - pop_cyc_q[n-1] != 1) begin gaps++; gap_len = pop_cyc_q[n] - pop_cyc_q[n-1]; end
        checks++; if (gaps != 1 || gap_len != 6) $display("FAIL bp_gaps got %0d gaps len %0d exp 1 gap len 6", gaps, gap_len); else passes++;
        checks++; if (rd_cnt != 36) $display("FAIL bp_reads got %0d exp 36", rd_cnt); else passes++;
    endtask

    task automatic test_cfg_err();
        clear_mon();
        start_job(4, 8, 5, 1, 0);
        checks++; if ({done, cfg_err, busy} !== 3'b110) $display("FAIL cfg_k_gt_w got done,err,busy=%b exp 110", {done, cfg_err, busy}); else passes++;
        @(posedge clk); #1;
        checks++; if ({done, cfg_err} !== 2'b01) $display("FAIL cfg_after got done,err=%b exp 01", {done, cfg_err}); else passes++;
        repeat (3) begin @(posedge clk); #1; end
        start_job(4, 4, 3, 0, 0);
        checks++; if ({done, cfg_err} !== 2'b11) $display("FAIL cfg_s0 got done,err=%b exp 11", {done, cfg_err}); else passes++;
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (rd_cnt != 0) $display("FAIL cfg_no_reads got %0d exp 0", rd_cnt); else passes++;
        clear_mon(); build_exp(3, 3, 3, 1, 7);
        start_job(3, 3, 3, 1, 7);
        checks++; if ({cfg_err, busy} !== 2'b01) $display("FAIL cfg_clear got err,busy=%b exp 01", {cfg_err, busy}); else passes++;
        wait_done();
        checks++; if (got_q.size() != 9) $display("FAIL cfg_ok_count got %0d exp 9", got_q.size()); else passes++;
        for (int n = 0; n < exp_q.size(); n++) begin
            checks++;
            if (n >= got_q.size()) $display("FAIL cfg_ok_elem[%0d] got none exp %h", n, exp_q[n]);
            else if (got_q[n] !== exp_q[n]) $display("FAIL cfg_ok_elem[%0d] got %h exp %h", n, got_q[n], exp_q[n]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_run();
        clear_mon();
        start_job(4, 4, 3, 1, 0);
        repeat (10) begin @(posedge clk); #1; end
        nrst = 1'b0; #1;
        checks++; if ({out_valid, mem_rd_en, busy, done} !== 4'b0) $display("FAIL mid_rst_ctrl got %b exp 0000", {out_valid, mem_rd_en, busy, done}); else passes++;
        checks++; if ({out_data, out_last, win_row, win_col} !== 29'h0) $display("FAIL mid_rst_data got %h exp 0", {out_data, out_last, win_row, win_col}); else passes++;
        @(posedge clk); #1;
        checks++; if ({out_valid, mem_rd_en, busy} !== 3'b0) $display("FAIL mid_rst_hold got %b exp 000", {out_valid, mem_rd_en, busy}); else passes++;
        nrst = 1'b1;
        @(posedge clk); #1;
        clear_mon(); build_exp(5, 5, 3, 2, 100);
        start_job(5, 5, 3, 2, 100);
        wait_done();
        checks++; if (timed_out) $display("FAIL mid_timeout got no done exp done"); else passes++;
        checks++; if (got_q.size() != 36) $display("FAIL mid_count got %0d exp 36", got_q.size()); else passes++;
        for (int n = 0; n < exp_q.size(); n++) begin
            checks++;
            if (n >= got_q.size()) $display("FAIL mid_elem[%0d] got none exp %h", n, exp_q[n]);
            else if (got_q[n] !== exp_q[n]) $display("FAIL mid_elem[%0d] got %h exp %h", n, got_q[n], exp_q[n]);
            else passes++;
        end
        checks++; if (done_cnt != 1) $display("FAIL mid_done_cnt got %0d exp 1", done_cnt); else passes++;
    endtask

    task automatic test_busy_start_wrap();
        int s0;
        clear_mon(); build_exp(4, 4, 3, 1, 4090);
        start_job(4, 4, 3, 1, 4090);
        s0 = start_cyc;
        repeat (5) begin @(posedge clk); #1; end
        img_w = 6'd5; img_h = 6'd5; stride = 2'd2; base_addr = 12'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        repeat (10) begin @(posedge clk); #1; end
        checks++; if (timed_out) $display("FAIL wrap_timeout got no done exp done"); else passes++;
        checks++; if (done_cyc - s0 != 39) $display("FAIL wrap_done_time got %0d exp 39", done_cyc - s0); else passes++;
        checks++; if (done_cnt != 1) $display("FAIL wrap_done_cnt got %0d exp 1", done_cnt); else passes++;
        checks++; if (rd_cnt != 36 || busy !== 1'b0) $display("FAIL wrap_reads got %0d busy %b exp 36 busy 0", rd_cnt, busy); else passes++;
        checks++; if (got_q.size() != 36) $display("FAIL wrap_count got %0d exp 36", got_q.size()); else passes++;
        for (int n = 0; n < exp_q.size(); n++) begin
            checks++;
            if (n >= got_q.size()) $display("FAIL wrap_elem[%0d] got none exp %h", n, exp_q[n]);
            else if (got_q[n] !== exp_q[n]) $display("FAIL wrap_elem[%0d] got %h exp %h", n, got_q[n], exp_q[n]);
            else passes++;
        end
        checks++; if (got_q.size() > 5 && (got_q[2].data !== 16'd4092 || got_q[5].data !== 16'd0)) $display("FAIL wrap_addr got %0d,%0d exp 4092,0", got_q[2].data, got_q[5].data); else passes++;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 16'(a);
        test_reset();
        test_basic();
        test_stride2();
        test_backpressure();
        test_cfg_err();
        test_reset_mid_run();
        test_busy_start_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
